scratchpad_copy_engine: RTL and testbench
=========================================

Name: scratchpad_copy_engine

Overview:
- Bus initiator that drives the scratchpad's en/write/addr/len/wdata/rdata interface.
- Copies COUNT elements of a fixed size from a source to a destination address range inside the scratchpad window.
- Started by a one-cycle command pulse; reports completion and error status.
- Sits between a control/CSR front end and the scratchpad RAM, and is the only master on that port while busy.

Parameters:
- CHUNK_SIZE, 512, bytes per chunk.
- NUM_CHUNKS, 1024, number of chunks; window size SIZE = CHUNK_SIZE*NUM_CHUNKS.
- SCRATCHPAD_BASE, 64'h0300000000000000, first byte address of the window.
- COUNT_WIDTH, 32, width of the element-count field.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command pulse; sampled only in IDLE.
- src  in  64  source byte address, absolute.
- dst  in  64  destination byte address, absolute.
- len  in  2  element size: 00 byte, 01 half, 10 word, 11 double.
- count  in  COUNT_WIDTH  number of elements.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = rejected command.
- mem_en  out  1  scratchpad access enable.
- mem_write  out  1  1 = write, 0 = read.
- mem_addr  out  64  absolute byte address.
- mem_len  out  2  equals the latched len.
- mem_wdata  out  64  write data, low bits significant for sub-double lengths.
- mem_rdata  in  64  read data, valid the cycle after a read access, zero-extended.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; busy, done, err, mem_en, mem_write = 0; mem_addr, mem_wdata, mem_len = 0. Reset mid-transfer abandons the copy; destination is left partially written; no done pulse is issued.
- States: IDLE, CHECK, READ, CAPT, WRITE, FIN.
- IDLE: when start=1, latch src, dst, len and count, then go to CHECK. start in any other state is ignored.
- CHECK (busy=1): set err_q if any of the following hold (all arithmetic in 65 bits, no wrap):
  - src < BASE or dst < BASE;
  - src + count*esz > BASE+SIZE, or the same for dst, where esz = 1 << len;
  - src or dst not aligned to esz.
  - If err_q or count == 0, go to FIN; otherwise go to READ.
- READ: mem_en=1, mem_write=0, mem_addr=src_ptr. Next state CAPT.
- CAPT: mem_en=0; data_q <= mem_rdata. Next state WRITE.
- WRITE: mem_en=1, mem_write=1, mem_addr=dst_ptr, mem_wdata=data_q. At the edge: src_ptr += esz, dst_ptr += esz, remaining -= 1. Go to FIN if remaining was 1, otherwise READ.
- FIN: done=1 and err=err_q for exactly one cycle; busy stays 1. Next state IDLE, where busy=0.
- Timing: with start high in cycle 0, done is high in cycle 2+3*count; an error or count == 0 gives done in cycle 2. A new start is accepted in cycle 3+3*count at the earliest.
- Overlap: strictly ascending, element-by-element forward copy. When dst > src and the ranges overlap, source data is overwritten before it is read; this is the defined result and is not detected.
- Outputs mem_en and mem_write are combinational decodes of the registered state only, with no path from mem_rdata. All other outputs are registered.
- A rejected command issues no memory access.

Decomposition:
- Package scratchpad_pkg holds:
  - the len encoding enum (LEN_BYTE, LEN_HALF, LEN_WORD, LEN_DOUBLE);
  - default CHUNK_SIZE, NUM_CHUNKS and SCRATCHPAD_BASE constants;
  - the engine state enum;
  - function in_window(addr, bytes), shared with the scratchpad's own range assertions.
- Single module; no sub-module is warranted.

Test Plan (B = 64'h0300000000000000, SIZE = 0x80000):
- Doubles: preload B+0x00..0x18 with 0x11..0x44; start src=B, dst=B+0x100, len=11, count=4 -> writes at B+0x100, 0x108, 0x110, 0x118 with matching data, done=1/err=0 in cycle 14, busy high in cycles 1-14.
- count=0, src=B, dst=B+0x40 -> done=1/err=0 in cycle 2, mem_en never asserted.
- Misaligned: src=B+0x3, len=10, count=1 -> done=1/err=1 in cycle 2, no access. Repeat with src=B-8 -> err=1.
- Upper bound: dst=B+0x7FFF8, len=11, count=1 -> success. dst=B+0x7FFF8, count=2 -> err=1 with no access.
- Forward overlap: bytes B+0x10..0x12 = 0xA1, 0xB2, 0xC3; src=B+0x10, dst=B+0x11, len=00, count=3 -> B+0x11..0x13 all 0xA1.
- Reset: assert rst_n=0 in the READ of element 3 of an 8-double copy -> mem_en=0 and busy=0 immediately, no done pulse; after release a fresh start completes normally. Also, start pulsed while busy -> ignored, no change to the ongoing transfer.

Source files
------------

// File: rtl/scratchpad_pkg.sv
// Shared scratchpad definitions: access-size encoding, window geometry, copy-engine states
// and the window range check also used by the scratchpad's own assertions.
package scratchpad_pkg;

    typedef enum logic [1:0] {
        LEN_BYTE   = 2'b00,
        LEN_HALF   = 2'b01,
        LEN_WORD   = 2'b10,
        LEN_DOUBLE = 2'b11
    } len_e;

    localparam int unsigned   DEFAULT_CHUNK_SIZE      = 512;
    localparam int unsigned   DEFAULT_NUM_CHUNKS      = 1024;
    localparam logic [63:0]   DEFAULT_SCRATCHPAD_BASE = 64'h0300_0000_0000_0000;
    localparam logic [64:0]   DEFAULT_WINDOW_SIZE     =
        65'(DEFAULT_CHUNK_SIZE) * 65'(DEFAULT_NUM_CHUNKS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_READ  = 3'd2,
        ST_CAPT  = 3'd3,
        ST_WRITE = 3'd4,
        ST_FIN   = 3'd5
    } engine_state_e;

    // True when [addr, addr+bytes) lies inside the window; 65-bit so the end never wraps.
    function automatic logic in_window(input logic [63:0] addr,
                                       input logic [64:0] bytes,
                                       input logic [63:0] base = DEFAULT_SCRATCHPAD_BASE,
                                       input logic [64:0] size = DEFAULT_WINDOW_SIZE);
        logic [64:0] last;
        last = {1'b0, addr} + bytes;
        return (addr >= base) && (last <= ({1'b0, base} + size));
    endfunction

endpackage

// File: rtl/scratchpad_copy_engine.sv
// Forward element-by-element copy engine; sole scratchpad master while busy.
// Each element costs READ, CAPT, WRITE; commands are range/alignment checked first.
module scratchpad_copy_engine
    import scratchpad_pkg::*;
#(
    parameter int unsigned CHUNK_SIZE      = DEFAULT_CHUNK_SIZE,
    parameter int unsigned NUM_CHUNKS      = DEFAULT_NUM_CHUNKS,
    parameter logic [63:0] SCRATCHPAD_BASE = DEFAULT_SCRATCHPAD_BASE,
    parameter int unsigned COUNT_WIDTH     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [63:0]            src,
    input  logic [63:0]            dst,
    input  logic [1:0]             len,
    input  logic [COUNT_WIDTH-1:0] count,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   mem_en,
    output logic                   mem_write,
    output logic [63:0]            mem_addr,
    output logic [1:0]             mem_len,
    output logic [63:0]            mem_wdata,
    input  logic [63:0]            mem_rdata
);

    localparam logic [64:0] WINDOW_SIZE = 65'(CHUNK_SIZE) * 65'(NUM_CHUNKS);

    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] CHECK = ST_CHECK;
    localparam logic [2:0] READ  = ST_READ;
    localparam logic [2:0] CAPT  = ST_CAPT;
    localparam logic [2:0] WRITE = ST_WRITE;
    localparam logic [2:0] FIN   = ST_FIN;

    logic [2:0]             state_q, state_d;
    logic [63:0]            src_ptr_q, dst_ptr_q;
    logic [COUNT_WIDTH-1:0] rem_q;
    len_e                   len_q;
    logic [63:0]            mem_addr_q, mem_wdata_q;
    logic                   busy_q, done_q, err_q;

    logic [64:0] span;
    logic [2:0]  align_mask;
    logic        misalign;
    logic        check_fail;
    logic [63:0] esz;

    assign esz        = 64'd1 << len_q;
    assign span       = 65'(rem_q) << len_q;
    assign align_mask = 3'((4'd1 << len_q) - 4'd1);
    assign misalign   = |((src_ptr_q[2:0] | dst_ptr_q[2:0]) & align_mask);
    assign check_fail = !in_window(src_ptr_q, span, SCRATCHPAD_BASE, WINDOW_SIZE) ||
                        !in_window(dst_ptr_q, span, SCRATCHPAD_BASE, WINDOW_SIZE) ||
                        misalign;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CHECK;
            CHECK:   state_d = (check_fail || rem_q == '0) ? FIN : READ;
            READ:    state_d = CAPT;
            CAPT:    state_d = WRITE;
            WRITE:   state_d = (rem_q == COUNT_WIDTH'(1)) ? FIN : READ;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // mem_addr is preloaded one state early so it is registered yet correct in READ/WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            rem_q       <= '0;
            len_q       <= LEN_BYTE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == FIN);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_ptr_q <= src;
                        dst_ptr_q <= dst;
                        len_q     <= len_e'(len);
                        rem_q     <= count;
                        busy_q    <= 1'b1;
                        err_q     <= 1'b0;
                    end
                end
                CHECK: begin
                    err_q      <= check_fail;
                    mem_addr_q <= src_ptr_q;
                end
                CAPT: begin
                    mem_wdata_q <= mem_rdata;
                    mem_addr_q  <= dst_ptr_q;
                end
                WRITE: begin
                    src_ptr_q  <= src_ptr_q + esz;
                    dst_ptr_q  <= dst_ptr_q + esz;
                    rem_q      <= rem_q - COUNT_WIDTH'(1);
                    mem_addr_q <= src_ptr_q + esz;
                end
                FIN:     busy_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign mem_en    = (state_q == READ) || (state_q == WRITE);
    assign mem_write = (state_q == WRITE);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_len   = len_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_scratchpad_copy_engine.sv
// Directed bench for scratchpad_copy_engine with a byte-addressed scratchpad model.
module tb_scratchpad_copy_engine;

    localparam logic [63:0] B = 64'h0300_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] src = '0;
    logic [63:0] dst = '0;
    logic [1:0]  len = '0;
    logic [31:0] count = '0;
    logic        busy, done, err, mem_en, mem_write;
    logic [63:0] mem_addr, mem_wdata;
    logic [1:0]  mem_len;
    logic [63:0] mem_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int acc_cnt = 0;

    bit [7:0] mem [logic [63:0]];

    scratchpad_copy_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_en    (mem_en),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_len   (mem_len),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd_byte(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [63:0] rd64(input logic [63:0] a);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = rd_byte(a + 64'(i));
        return v;
    endfunction

    // Memory model acts mid-cycle so it never races the DUT clock edge.
    always @(negedge clk) begin
        if (mem_en) begin
            acc_cnt = acc_cnt + 1;
            if (mem_write) begin
                for (int i = 0; i < (1 << mem_len); i++)
                    mem[mem_addr + 64'(i)] = mem_wdata[8*i +: 8];
            end else begin
                logic [63:0] v;
                v = '0;
                for (int i = 0; i < (1 << mem_len); i++)
                    v[8*i +: 8] = rd_byte(mem_addr + 64'(i));
                mem_rdata = v;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one command; cycle 0 is the cycle start is high, counting negedges after it.
    task automatic run_cmd(input logic [63:0] s, input logic [63:0] d, input logic [1:0] l,
                           input logic [31:0] c, input int poke,
                           output int dcyc, output logic derr, output int nacc,
                           output logic busy_ok);
        int n;
        @(negedge clk);
        src = s; dst = d; len = l; count = c; start = 1'b1;
        acc_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        dcyc = -1; derr = 1'bx; busy_ok = 1'b1;
        while (n < 200) begin
            if (n == poke) begin
                src = B + 64'h40; dst = B; len = 2'b00; count = 0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                dcyc = n; derr = err;
                break;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        nacc = acc_cnt;
    endtask

    typedef struct {
        string       name;
        logic [63:0] s;
        logic [63:0] d;
        logic [1:0]  l;
        logic [31:0] c;
        int          exp_cyc;
        logic        exp_err;
        int          exp_acc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int dc, na;
        logic de, bok;

        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 8; b++)
                mem[B + 64'(8*i + b)] = (b == 0) ? 8'(8'h11 * (i + 1)) : 8'h00;

        vecs[0] = '{"doubles",    B,           B + 64'h100,   2'b11, 32'd4, 14, 1'b0, 8};
        vecs[1] = '{"count0",     B,           B + 64'h40,    2'b11, 32'd0, 2,  1'b0, 0};
        vecs[2] = '{"misalign",   B + 64'h3,   B + 64'h40,    2'b10, 32'd1, 2,  1'b1, 0};
        vecs[3] = '{"below",      B - 64'h8,   B + 64'h40,    2'b11, 32'd1, 2,  1'b1, 0};
        vecs[4] = '{"top_ok",     B,           B + 64'h7FFF8, 2'b11, 32'd1, 5,  1'b0, 2};
        vecs[5] = '{"top_over",   B,           B + 64'h7FFF8, 2'b11, 32'd2, 2,  1'b1, 0};
        vecs[6] = '{"dst_misal",  B,           B + 64'h2,     2'b10, 32'd1, 2,  1'b1, 0};
        vecs[7] = '{"past_end",   B + 64'h80000, B,           2'b00, 32'd1, 2,  1'b1, 0};

        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_write", 64'(mem_write), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_mem_len", 64'(mem_len), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].s, vecs[i].d, vecs[i].l, vecs[i].c, -1, dc, de, na, bok);
            check({vecs[i].name, "_done_cycle"}, 64'(dc), 64'(vecs[i].exp_cyc));
            check({vecs[i].name, "_err"}, 64'(de), 64'(vecs[i].exp_err));
            check({vecs[i].name, "_accesses"}, 64'(na), 64'(vecs[i].exp_acc));
            check({vecs[i].name, "_busy_held"}, 64'(bok), 64'd1);
            @(negedge clk);
            check({vecs[i].name, "_done_pulse"}, 64'(done), 64'd0);
            check({vecs[i].name, "_busy_drop"}, 64'(busy), 64'd0);
        end

        check("doubles_d0", rd64(B + 64'h100), 64'h11);
        check("doubles_d1", rd64(B + 64'h108), 64'h22);
        check("doubles_d2", rd64(B + 64'h110), 64'h33);
        check("doubles_d3", rd64(B + 64'h118), 64'h44);
        check("top_ok_data", rd64(B + 64'h7FFF8), 64'h11);

        // Forward overlap smears the first byte across the destination.
        mem[B + 64'h10] = 8'hA1; mem[B + 64'h11] = 8'hB2; mem[B + 64'h12] = 8'hC3;
        run_cmd(B + 64'h10, B + 64'h11, 2'b00, 32'd3, -1, dc, de, na, bok);
        check("overlap_done_cycle", 64'(dc), 64'd11);
        check("overlap_err", 64'(de), 64'd0);
        check("overlap_b10", 64'(rd_byte(B + 64'h10)), 64'hA1);
        check("overlap_b11", 64'(rd_byte(B + 64'h11)), 64'hA1);
        check("overlap_b12", 64'(rd_byte(B + 64'h12)), 64'hA1);
        check("overlap_b13", 64'(rd_byte(B + 64'h13)), 64'hA1);

        // Start while busy must not disturb the running transfer.
        run_cmd(B, B + 64'h300, 2'b11, 32'd2, 3, dc, de, na, bok);
        check("busy_start_done_cycle", 64'(dc), 64'd8);
        check("busy_start_err", 64'(de), 64'd0);
        check("busy_start_accesses", 64'(na), 64'd4);
        check("busy_start_d0", rd64(B + 64'h300), 64'h11);
        check("busy_start_d1", rd64(B + 64'h308), 64'h22);
        @(negedge clk);
        check("busy_start_idle", 64'(busy), 64'd0);

        // Reset during the READ of element 3 of an 8-double copy.
        @(negedge clk);
        src = B; dst = B + 64'h200; len = 2'b11; count = 32'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("rst_mid_pre_en", 64'(mem_en), 64'd1);
        check("rst_mid_pre_we", 64'(mem_write), 64'd0);
        check("rst_mid_pre_addr", mem_addr, B + 64'h10);
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_en", 64'(mem_en), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        check("rst_mid_done_held", 64'(done), 64'd0);
        rst_n = 1'b1;
        check("rst_mid_e1", rd64(B + 64'h200), 64'h11);
        check("rst_mid_e2", rd64(B + 64'h208), 64'h22);
        check("rst_mid_e3", rd64(B + 64'h210), 64'h0);

        run_cmd(B, B + 64'h400, 2'b11, 32'd2, -1, dc, de, na, bok);
        check("post_rst_done_cycle", 64'(dc), 64'd8);
        check("post_rst_err", 64'(de), 64'd0);
        check("post_rst_busy_held", 64'(bok), 64'd1);
        check("post_rst_d0", rd64(B + 64'h400), 64'h11);
        check("post_rst_d1", rd64(B + 64'h408), 64'h22);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
